// File: rtl/lock_pkg.sv
// Shared types and widths for the lock timing/attempt-policy controller.
package lock_pkg;

  localparam int unsigned SECS_W  = 6;
  localparam int unsigned FAIL_W  = 3;
  localparam int unsigned PRESC_W = 29;

  localparam int unsigned DEF_TICK_DIV    = 100_000_000;
  localparam int unsigned DEF_MAX_FAILS   = 3;
  localparam int unsigned DEF_ENTRY_SEC   = 10;
  localparam int unsigned DEF_LOCKOUT_SEC = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running seconds prescaler; emits a one-cycle enable in the last cycle of each period.
module tick_prescaler
  import lock_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_cnt_nxt;
  logic               r_tick;

  always_comb begin
    w_cnt_nxt = r_cnt + PRESC_W'(1);
    if (clear || (r_cnt == LAST)) begin
      w_cnt_nxt = '0;
    end
  end

  // Tick register tracks the count so it is high exactly while the count sits at LAST.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/lock_timer_ctrl.sv
// Entry-timeout / lockout sequencer and consecutive-failure counter for the digital lock.
module lock_timer_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned MAX_FAILS   = DEF_MAX_FAILS,
  parameter int unsigned ENTRY_SEC   = DEF_ENTRY_SEC,
  parameter int unsigned LOCKOUT_SEC = DEF_LOCKOUT_SEC
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              key_press,
  input  logic              code_submit,
  input  logic              code_ok,
  output logic              tick_1hz,
  output logic              entry_active,
  output logic              locked_out,
  output logic              unlock,
  output logic              timeout,
  output logic [FAIL_W-1:0] fail_count,
  output logic [SECS_W-1:0] secs_left
);

  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SECS_W-1:0] r_secs;
  logic [SECS_W-1:0] w_secs_nxt;
  logic [FAIL_W-1:0] r_fail;
  logic [FAIL_W-1:0] w_fail_nxt;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              r_entry;
  logic              r_locked;
  logic              r_unlock;
  logic              r_timeout;
  logic              w_unlock;
  logic              w_timeout;
  logic              w_clear;
  logic              w_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk_in (clk_in),
    .rst    (rst),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  assign w_fail_inc = r_fail + FAIL_W'(1);

  // Submission beats key_press, which beats tick expiry; LOCKOUT ignores keypad input.
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_fail_nxt  = r_fail;
    w_unlock    = 1'b0;
    w_timeout   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (code_submit) begin
          if (code_ok) begin
            w_unlock    = 1'b1;
            w_fail_nxt  = '0;
            w_state_nxt = ST_IDLE;
            w_secs_nxt  = '0;
          end else if (w_fail_inc >= FAIL_MAX || r_fail >= FAIL_MAX) begin
            w_fail_nxt  = FAIL_MAX;
            w_state_nxt = ST_LOCKOUT;
            w_secs_nxt  = SECS_W'(LOCKOUT_SEC);
            w_clear     = 1'b1;
          end else begin
            w_fail_nxt  = w_fail_inc;
            w_state_nxt = ST_IDLE;
            w_secs_nxt  = '0;
          end
        end else if (key_press) begin
          w_state_nxt = ST_ENTRY;
          w_secs_nxt  = SECS_W'(ENTRY_SEC);
          w_clear     = 1'b1;
        end else if (w_tick && (r_state == ST_ENTRY)) begin
          if (r_secs == SECS_W'(1)) begin
            w_secs_nxt  = '0;
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_secs != '0) begin
            w_secs_nxt = r_secs - SECS_W'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (w_tick) begin
          if (r_secs == SECS_W'(1)) begin
            w_secs_nxt  = '0;
            w_fail_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else if (r_secs != '0) begin
            w_secs_nxt = r_secs - SECS_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_secs_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_secs    <= '0;
      r_fail    <= '0;
      r_entry   <= 1'b0;
      r_locked  <= 1'b0;
      r_unlock  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_secs    <= w_secs_nxt;
      r_fail    <= w_fail_nxt;
      r_entry   <= (w_state_nxt == ST_ENTRY);
      r_locked  <= (w_state_nxt == ST_LOCKOUT);
      r_unlock  <= w_unlock;
      r_timeout <= w_timeout;
    end
  end

  assign tick_1hz     = w_tick;
  assign entry_active = r_entry;
  assign locked_out   = r_locked;
  assign unlock       = r_unlock;
  assign timeout      = r_timeout;
  assign fail_count   = r_fail;
  assign secs_left    = r_secs;

endmodule

// File: tb/tb_lock_timer_ctrl.sv
// Directed plus random stimulus for lock_timer_ctrl against a behavioural reference model.
module tb_lock_timer_ctrl;

  localparam int DIV  = 4;
  localparam int MAXF = 3;
  localparam int ESEC = 2;
  localparam int LSEC = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       key_press = 1'b0;
  logic       code_submit = 1'b0;
  logic       code_ok = 1'b0;
  logic       tick_1hz, entry_active, locked_out, unlock, timeout;
  logic [2:0] fail_count;
  logic [5:0] secs_left;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=idle 1=entry 2=lockout; phase = cycles since last restart mod DIV.
  int m_mode = 0, m_phase = 0, m_secs = 0, m_fails = 0;
  int m_unlock = 0, m_timeout = 0;

  lock_timer_ctrl #(
    .TICK_DIV    (DIV),
    .MAX_FAILS   (MAXF),
    .ENTRY_SEC   (ESEC),
    .LOCKOUT_SEC (LSEC)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .key_press    (key_press),
    .code_submit  (code_submit),
    .code_ok      (code_ok),
    .tick_1hz     (tick_1hz),
    .entry_active (entry_active),
    .locked_out   (locked_out),
    .unlock       (unlock),
    .timeout      (timeout),
    .fail_count   (fail_count),
    .secs_left    (secs_left)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit k, input bit c, input bit o);
    bit tk, restart;
    m_unlock  = 0;
    m_timeout = 0;
    if (r) begin
      m_mode = 0; m_phase = 0; m_secs = 0; m_fails = 0;
      return;
    end
    tk = (m_phase == DIV - 1);
    restart = 0;
    if (m_mode != 2 && c) begin
      if (o) begin
        m_unlock = 1; m_fails = 0; m_mode = 0; m_secs = 0;
      end else if (m_fails + 1 >= MAXF) begin
        m_fails = MAXF; m_mode = 2; m_secs = LSEC; restart = 1;
      end else begin
        m_fails++; m_mode = 0; m_secs = 0;
      end
    end else if (m_mode != 2 && k) begin
      m_mode = 1; m_secs = ESEC; restart = 1;
    end else if (tk && m_mode != 0 && m_secs > 0) begin
      m_secs--;
      if (m_secs == 0) begin
        if (m_mode == 1) m_timeout = 1;
        else m_fails = 0;
        m_mode = 0;
      end
    end
    m_phase = restart ? 0 : (m_phase + 1) % DIV;
  endtask

  task automatic step(input bit k, input bit c, input bit o, input bit r);
    key_press   = k;
    code_submit = c;
    code_ok     = o;
    rst         = r;
    @(posedge clk_in);
    model_edge(r, k, c, o);
    #1;
    key_press   = 1'b0;
    code_submit = 1'b0;
    code_ok     = 1'b0;
    chk("tick_1hz",     int'(tick_1hz),     int'(m_phase == DIV - 1));
    chk("entry_active", int'(entry_active), int'(m_mode == 1));
    chk("locked_out",   int'(locked_out),   int'(m_mode == 2));
    chk("unlock",       int'(unlock),       m_unlock);
    chk("timeout",      int'(timeout),      m_timeout);
    chk("fail_count",   int'(fail_count),   m_fails);
    chk("secs_left",    int'(secs_left),    m_secs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int n;
    bit seen;
    int fails_before;

    // Power-on reset.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_secs", int'(secs_left), 0);
    chk("reset_fail", int'(fail_count), 0);

    // Entry timeout.
    step(1, 0, 0, 0);
    chk("entry_load_secs", int'(secs_left), ESEC);
    chk("entry_active_on", int'(entry_active), 1);
    idle(4);
    chk("entry_one_sec", int'(secs_left), 1);
    idle(3);
    chk("no_early_timeout", int'(timeout), 0);
    idle(1);
    chk("timeout_pulse", int'(timeout), 1);
    chk("timeout_to_idle", int'(entry_active), 0);
    idle(1);
    chk("timeout_one_cycle", int'(timeout), 0);

    // key_press colliding with the expiring tick reloads instead of timing out.
    step(1, 0, 0, 0);
    idle(7);
    step(1, 0, 0, 0);
    chk("collide_no_timeout", int'(timeout), 0);
    chk("collide_reload", int'(secs_left), ESEC);

    // Failed submission beats same-cycle key_press.
    fails_before = int'(fail_count);
    step(1, 1, 0, 0);
    chk("collide_fail_counted", int'(fail_count), fails_before + 1);
    chk("collide_idle", int'(entry_active), 0);

    // Correct code.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("unlock_pulse", int'(unlock), 1);
    chk("unlock_clears_fails", int'(fail_count), 0);
    idle(1);
    chk("unlock_one_cycle", int'(unlock), 0);

    // Lockout after three failures; no unlock while locked.
    step(0, 1, 0, 0);
    chk("fail_1", int'(fail_count), 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("fail_2", int'(fail_count), 2);
    step(0, 1, 0, 0);
    chk("fail_3", int'(fail_count), 3);
    chk("lockout_on", int'(locked_out), 1);
    chk("lockout_secs", int'(secs_left), LSEC);
    step(0, 1, 1, 0);
    chk("lockout_no_unlock", int'(unlock), 0);
    idle(10);
    chk("lockout_still", int'(locked_out), 1);
    idle(1);
    chk("lockout_released", int'(locked_out), 0);
    chk("lockout_fail_clear", int'(fail_count), 0);

    // Reset held mid-lockout.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(2);
    chk("pre_reset_locked", int'(locked_out), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_secs", int'(secs_left), 0);
    chk("rst_fail", int'(fail_count), 0);
    chk("rst_tick", int'(tick_1hz), 0);

    // Prescaler restart on load.
    seen = 0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      step(0, 0, 0, 0);
      if (tick_1hz) seen = 1;
    end
    chk("free_run_tick_seen", int'(seen), 1);
    idle(2);
    step(1, 0, 0, 0);
    n = 0;
    seen = 0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      step(0, 0, 0, 0);
      n++;
      if (tick_1hz) seen = 1;
    end
    chk("restart_tick_seen", int'(seen), 1);
    chk("restart_tick_delay", n, DIV - 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
